// File: rtl/conv_pkg.sv
// Shared types and Q-format helpers for the convolution pipeline blocks.
package conv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        DRAIN = 3'd2,
        CAPT  = 3'd3,
        OUT   = 3'd4
    } state_t;

    function automatic int taps_of(input int k);
        return k * k;
    endfunction

    localparam int TAPS_K3 = taps_of(3);

    // Largest / smallest representable N-bit two's-complement value, sign-extended to 64 bits.
    function automatic logic signed [63:0] q_max(input int n);
        return (64'sd1 <<< (n - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] q_min(input int n);
        return -(64'sd1 <<< (n - 1));
    endfunction

endpackage

// File: rtl/conv_q_sat.sv
// Combinational 2N -> N narrowing: arithmetic shift right by Q, then clamp to the N-bit range.
module conv_q_sat
    import conv_pkg::*;
#(
    parameter int N = 16,
    parameter int Q = 12
) (
    input  logic [2*N-1:0] i_acc,
    output logic [N-1:0]   o_res,
    output logic           o_sat
);

    localparam logic signed [63:0] MAXV = q_max(N);
    localparam logic signed [63:0] MINV = q_min(N);

    logic signed [2*N-1:0] w_sh;
    logic signed [63:0]    w_sh64;

    // >>> on a signed operand truncates toward minus infinity.
    assign w_sh   = $signed(i_acc) >>> Q;
    assign w_sh64 = 64'(w_sh);

    always_comb begin
        o_res = w_sh[N-1:0];
        o_sat = 1'b0;
        if (w_sh64 > MAXV) begin
            o_res = MAXV[N-1:0];
            o_sat = 1'b1;
        end else if (w_sh64 < MINV) begin
            o_res = MINV[N-1:0];
            o_sat = 1'b1;
        end
    end

endmodule

// File: rtl/conv_mac_ctrl.sv
// Sequencer for one K x K convolution output pixel on the shared MAC: tap walk,
// bias-seeded accumulation via the MAC c-input, Q-format saturation and valid/ready output.
module conv_mac_ctrl
    import conv_pkg::*;
#(
    parameter int N  = 16,
    parameter int Q  = 12,
    parameter int K  = 3,
    parameter int AW = $clog2(K * K)
) (
    input  logic           clk,
    input  logic           sclr_n,
    input  logic           start_i,
    output logic           busy_o,
    output logic           rd_en_o,
    output logic [AW-1:0]  tap_addr_o,
    input  logic [N-1:0]   pix_i,
    input  logic [N-1:0]   coef_i,
    input  logic [N-1:0]   bias_i,
    output logic [N-1:0]   mac_a_o,
    output logic [N-1:0]   mac_b_o,
    output logic [2*N-1:0] mac_c_o,
    output logic           mac_ce_o,
    output logic           mac_sclr_o,
    input  logic [2*N-1:0] mac_r_i,
    output logic [N-1:0]   res_o,
    output logic           res_valid_o,
    input  logic           res_ready_i,
    output logic           sat_o
);

    localparam int TAPS = taps_of(K);
    localparam logic [AW-1:0] LAST_TAP = AW'(TAPS - 1);

    state_t r_state, w_state_nxt;

    logic [AW-1:0]  r_tap;
    logic           r_rd_en;
    logic           r_ce;
    logic           r_first;
    logic           r_busy;
    logic           r_sclr;
    logic           r_valid;
    logic [N-1:0]   r_bias;
    logic [N-1:0]   r_res;
    logic           r_sat;

    logic           w_accept;
    logic [2*N-1:0] w_bias_q;
    logic [N-1:0]   w_res;
    logic           w_sat;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (!sclr_n) r_state <= IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end
            end
            RUN: begin
                if (r_tap == LAST_TAP) w_state_nxt = DRAIN;
            end
            DRAIN: w_state_nxt = CAPT;
            CAPT:  w_state_nxt = OUT;
            OUT: begin
                // Start is only honoured together with the handshake; there is no queue.
                if (res_ready_i && start_i) begin
                    w_state_nxt = RUN;
                    w_accept    = 1'b1;
                end else if (res_ready_i) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- registered outputs, tap counter, ce pipe ----------------
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            r_tap   <= '0;
            r_rd_en <= 1'b0;
            r_ce    <= 1'b0;
            r_first <= 1'b0;
            r_busy  <= 1'b0;
            r_sclr  <= 1'b1;
            r_valid <= 1'b0;
            r_bias  <= '0;
            r_res   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_rd_en <= (w_state_nxt == RUN);
            r_tap   <= (r_state == RUN && w_state_nxt == RUN) ? r_tap + AW'(1) : '0;
            // Memory data lands one cycle after the read strobe, so ce trails rd_en by one.
            r_ce    <= r_rd_en;
            r_first <= r_rd_en && (r_tap == '0);
            r_busy  <= (w_state_nxt != IDLE);
            r_sclr  <= (w_state_nxt == IDLE) || (w_state_nxt == OUT);
            r_valid <= (w_state_nxt == OUT);
            if (w_accept) r_bias <= bias_i;
            if (r_state == CAPT) begin
                r_res <= w_res;
                r_sat <= w_sat;
            end
        end
    end

    // ---------------- MAC interface ----------------
    assign w_bias_q = {{N{r_bias[N-1]}}, r_bias} << Q;

    assign mac_a_o    = pix_i;
    assign mac_b_o    = coef_i;
    assign mac_c_o    = !r_ce   ? '0       :
                        r_first ? w_bias_q : mac_r_i;
    assign mac_ce_o   = r_ce;
    assign mac_sclr_o = r_sclr;

    conv_q_sat #(
        .N (N),
        .Q (Q)
    ) u_q_sat (
        .i_acc (mac_r_i),
        .o_res (w_res),
        .o_sat (w_sat)
    );

    assign busy_o      = r_busy;
    assign rd_en_o     = r_rd_en;
    assign tap_addr_o  = r_tap;
    assign res_o       = r_res;
    assign res_valid_o = r_valid;
    assign sat_o       = r_sat;

endmodule

// File: tb/tb_conv_mac_ctrl.sv
// Directed and randomized checks of conv_mac_ctrl against a behavioural MAC, window/ROM memories
// and a reference convolution model.
module tb_conv_mac_ctrl;

    localparam int N    = 16;
    localparam int Q    = 12;
    localparam int K    = 3;
    localparam int TAPS = 9;
    localparam int AW   = 4;

    logic          clk = 1'b0;
    logic          sclr_n;
    logic          start_i;
    logic          busy_o;
    logic          rd_en_o;
    logic [AW-1:0] tap_addr_o;
    logic [N-1:0]  pix_i, coef_i, bias_i;
    logic [N-1:0]  mac_a_o, mac_b_o;
    logic [2*N-1:0] mac_c_o;
    logic          mac_ce_o, mac_sclr_o;
    logic [2*N-1:0] mac_r;
    logic [N-1:0]  res_o;
    logic          res_valid_o, res_ready_i, sat_o;

    logic [N-1:0]  pix_mem  [TAPS];
    logic [N-1:0]  coef_mem [TAPS];

    int n_tests = 0;
    int n_fail  = 0;
    int mon_rd  = 0;
    int mon_ce  = 0;
    int mon_bad = 0;
    int exp_tap = 0;

    always #5 clk = ~clk;

    conv_mac_ctrl #(.N(N), .Q(Q), .K(K), .AW(AW)) dut (
        .clk         (clk),
        .sclr_n      (sclr_n),
        .start_i     (start_i),
        .busy_o      (busy_o),
        .rd_en_o     (rd_en_o),
        .tap_addr_o  (tap_addr_o),
        .pix_i       (pix_i),
        .coef_i      (coef_i),
        .bias_i      (bias_i),
        .mac_a_o     (mac_a_o),
        .mac_b_o     (mac_b_o),
        .mac_c_o     (mac_c_o),
        .mac_ce_o    (mac_ce_o),
        .mac_sclr_o  (mac_sclr_o),
        .mac_r_i     (mac_r),
        .res_o       (res_o),
        .res_valid_o (res_valid_o),
        .res_ready_i (res_ready_i),
        .sat_o       (sat_o)
    );

    // Window buffer / coefficient ROM with one-cycle read latency.
    always_ff @(posedge clk) begin
        if (rd_en_o) begin
            pix_i  <= pix_mem[tap_addr_o];
            coef_i <= coef_mem[tap_addr_o];
        end
    end

    // Behavioural MAC: registered r = a*b + c, wraps on overflow.
    always_ff @(posedge clk) begin
        if (mac_sclr_o)    mac_r <= '0;
        else if (mac_ce_o) mac_r <= $signed(mac_a_o) * $signed(mac_b_o) + $signed(mac_c_o);
    end

    always @(negedge clk) begin
        if (mac_ce_o) mon_ce++;
        if (rd_en_o) begin
            mon_rd++;
            if (int'(tap_addr_o) != exp_tap) mon_bad++;
            exp_tap = (exp_tap == TAPS - 1) ? 0 : exp_tap + 1;
        end else begin
            exp_tap = 0;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < TAPS; i++) begin
            pix_mem[i]  = '0;
            coef_mem[i] = '0;
        end
    endtask

    task automatic fill_mem(input logic [N-1:0] p, input logic [N-1:0] c);
        for (int i = 0; i < TAPS; i++) begin
            pix_mem[i]  = p;
            coef_mem[i] = c;
        end
    endtask

    function automatic void model(input logic [N-1:0] b, output logic [N-1:0] r, output logic s);
        logic signed [31:0] acc;
        logic signed [31:0] sh;
        acc = $signed({{16{b[15]}}, b}) <<< Q;
        for (int i = 0; i < TAPS; i++)
            acc = acc + $signed(pix_mem[i]) * $signed(coef_mem[i]);
        sh = acc >>> Q;
        if (sh > 32767)       begin r = 16'h7FFF; s = 1'b1; end
        else if (sh < -32768) begin r = 16'h8000; s = 1'b1; end
        else                  begin r = sh[15:0]; s = 1'b0; end
    endfunction

    // Called on a negedge with the DUT idle; returns at the negedge where valid is seen.
    task automatic run_px(input logic [N-1:0] b, output int lat);
        start_i = 1'b1;
        bias_i  = b;
        @(negedge clk);
        start_i = 1'b0;
        lat     = 1;
        while (!res_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_px(input string tag, input logic [N-1:0] b, input logic [N-1:0] er,
                         input logic es, input int stall);
        int lat, rd0, ce0, bad0;
        rd0 = mon_rd; ce0 = mon_ce; bad0 = mon_bad;
        run_px(b, lat);
        chk({tag, "_lat"}, lat, 12);
        repeat (stall) @(negedge clk);
        chk({tag, "_vld"},  res_valid_o, 1);
        chk({tag, "_res"},  res_o, er);
        chk({tag, "_sat"},  sat_o, es);
        chk({tag, "_ntap"}, mon_rd - rd0, TAPS);
        chk({tag, "_nce"},  mon_ce - ce0, TAPS);
        chk({tag, "_tseq"}, mon_bad - bad0, 0);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;
        chk({tag, "_done"}, {busy_o, res_valid_o}, 2'b00);
    endtask

    initial begin
        int lat, cnt;
        logic [N-1:0] er;
        logic         es;

        sclr_n = 1'b0; start_i = 1'b0; res_ready_i = 1'b0; bias_i = '0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_busy", busy_o, 0);
        chk("rst_rden", rd_en_o, 0);
        chk("rst_tap",  tap_addr_o, 0);
        chk("rst_ce",   mac_ce_o, 0);
        chk("rst_c",    mac_c_o, 0);
        chk("rst_sclr", mac_sclr_o, 1);
        chk("rst_res",  res_o, 0);
        chk("rst_vld",  res_valid_o, 0);
        chk("rst_sat",  sat_o, 0);
        sclr_n = 1'b1;
        @(negedge clk);

        // Identity kernel picks the centre pixel.
        clear_mem(); pix_mem[4] = 16'h1800; coef_mem[4] = 16'h1000;
        do_px("ident", 16'h0000, 16'h1800, 1'b0, 0);

        fill_mem(16'h1000, 16'h1000);
        do_px("satp", 16'h0800, 16'h7FFF, 1'b1, 0);
        fill_mem(16'h1000, 16'hF000);
        do_px("satn", 16'h0800, 16'h8000, 1'b1, 0);

        // -1 LSB product shifts to -1, not 0.
        clear_mem(); pix_mem[2] = 16'h0001; coef_mem[2] = 16'hFFFF;
        do_px("trunc", 16'h0000, 16'hFFFF, 1'b0, 0);

        // Stall in OUT with starts pulsed, then ready+start back-to-back.
        clear_mem(); pix_mem[4] = 16'h1800; coef_mem[4] = 16'h1000;
        run_px(16'h0100, lat);
        chk("stl_lat", lat, 12);
        for (int i = 0; i < 5; i++) begin
            start_i = (i % 2 == 0);
            bias_i  = 16'h7777;
            @(negedge clk);
            chk("stl_res", res_o, 16'h1900);
            chk("stl_vld", res_valid_o, 1);
        end
        res_ready_i = 1'b1; start_i = 1'b1; bias_i = 16'hF000;
        @(negedge clk);
        res_ready_i = 1'b0; start_i = 1'b0;
        chk("b2b_rden", rd_en_o, 1);
        chk("b2b_tap",  tap_addr_o, 0);
        chk("b2b_vld",  res_valid_o, 0);
        lat = 1;
        while (!res_valid_o && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b_lat", lat, 12);
        chk("b2b_res", res_o, 16'h0800);
        chk("b2b_sat", sat_o, 0);
        res_ready_i = 1'b1;
        @(negedge clk);
        res_ready_i = 1'b0;

        // Reset during tap 4 aborts the pixel.
        start_i = 1'b1; bias_i = 16'h0000;
        @(negedge clk);
        start_i = 1'b0;
        cnt = 0;
        while (!(rd_en_o && tap_addr_o == 4'd4) && cnt < 20) begin
            @(negedge clk);
            cnt++;
        end
        chk("ab_tap4", {rd_en_o, tap_addr_o}, {1'b1, 4'd4});
        sclr_n = 1'b0;
        @(negedge clk);
        sclr_n = 1'b1;
        chk("ab_busy", busy_o, 0);
        chk("ab_rden", rd_en_o, 0);
        chk("ab_tap",  tap_addr_o, 0);
        chk("ab_ce",   mac_ce_o, 0);
        chk("ab_c",    mac_c_o, 0);
        chk("ab_sclr", mac_sclr_o, 1);
        chk("ab_res",  res_o, 0);
        chk("ab_vld",  res_valid_o, 0);
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (res_valid_o) cnt++;
        end
        chk("ab_novld", cnt, 0);
        do_px("ab_fresh", 16'h0000, 16'h1800, 1'b0, 0);

        // Random pixels with random output stalls.
        for (int p = 0; p < 1000; p++) begin
            logic [N-1:0] b;
            for (int i = 0; i < TAPS; i++) begin
                pix_mem[i]  = N'($urandom);
                coef_mem[i] = N'($urandom);
            end
            b = N'($urandom);
            model(b, er, es);
            do_px("rnd", b, er, es, $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
